// File: rtl/pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_pkg: shared arbiter state encoding and datapath widths      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int C_DEFAULT_ADDR_W = 32;
  localparam int C_DEFAULT_DATA_W = 32;

endpackage
`default_nettype wire

// File: rtl/arb_timeout_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_timeout_cnt: clear/enable cycle counter, o_tc at TIMEOUT-1       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module arb_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/pipeline_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_mem_arbiter: IF/MEM arbiter for one single-port memory,     |
// | MEM has fixed priority. Option macro: ARB_PERF_COUNTERS_EN           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipeline_mem_arbiter
  import pipeline_pkg::*;
#(
  parameter int ADDR_W  = C_DEFAULT_ADDR_W,
  parameter int DATA_W  = C_DEFAULT_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              pipe_stall,
  output logic              timeout_err
`ifdef ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       if_starve_cycles
`endif
);

  arb_state_t        state_q, state_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              timeout_err_q, timeout_err_d;
  logic              busy;
  logic              tmo_tc;

  assign busy = (state_q == BUSY_D) || (state_q == BUSY_I);

  arb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (!busy),
    .i_en    (busy),
    .o_tc    (tmo_tc)
  );

  always_comb begin
    state_d       = state_q;
    ram_req_d     = ram_req_q;
    ram_we_d      = ram_we_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    if_ack_d      = 1'b0;
    d_ack_d       = 1'b0;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (d_req && !d_ack_q) begin
          state_d     = BUSY_D;
          ram_req_d   = 1'b1;
          ram_we_d    = d_we;
          ram_addr_d  = d_addr;
          ram_wdata_d = d_wdata;
        end else if (if_req && !if_ack_q) begin
          state_d     = BUSY_I;
          ram_req_d   = 1'b1;
          ram_we_d    = 1'b0;
          ram_addr_d  = if_addr;
          ram_wdata_d = '0;
        end
      end
      BUSY_D, BUSY_I: begin
        // Ready wins over a timeout landing on the same cycle.
        if (ram_ready || tmo_tc) begin
          state_d   = RESP;
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
          if (!ram_ready) begin
            timeout_err_d = 1'b1;
          end
          if (state_q == BUSY_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = (ram_ready && !ram_we_q) ? ram_rdata : '0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = ram_ready ? ram_rdata : '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ram_req_q     <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      if_ack_q      <= 1'b0;
      d_ack_q       <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ram_req_q     <= ram_req_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      if_ack_q      <= if_ack_d;
      d_ack_q       <= d_ack_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ram_req     = ram_req_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_ack      = if_ack_q;
  assign d_ack       = d_ack_q;
  assign timeout_err = timeout_err_q;
  // Low in the ack cycle so the pipeline advances exactly once per access.
  assign pipe_stall  = (d_req && !d_ack_q) || (if_req && !if_ack_q);

`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] if_starve_cycles_q, if_starve_cycles_d;

  always_comb begin
    stall_cycles_d     = stall_cycles_q;
    if_starve_cycles_d = if_starve_cycles_q;
    if (pipe_stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (if_req && (state_q == BUSY_D) && (if_starve_cycles_q != '1)) begin
      if_starve_cycles_d = if_starve_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q     <= '0;
      if_starve_cycles_q <= '0;
    end else begin
      stall_cycles_q     <= stall_cycles_d;
      if_starve_cycles_q <= if_starve_cycles_d;
    end
  end

  assign stall_cycles     = stall_cycles_q;
  assign if_starve_cycles = if_starve_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipeline_mem_arbiter: directed self-checking bench (TIMEOUT=8)    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipeline_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;
  logic              pipe_stall;
  logic              timeout_err;
`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       if_starve_cycles;
  logic [31:0]       stall_base;
  logic [31:0]       starve_base;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pipeline_mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ack      (if_ack),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ack       (d_ack),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_ready   (ram_ready),
    .pipe_stall  (pipe_stall),
    .timeout_err (timeout_err)
`ifdef ARB_PERF_COUNTERS_EN
    ,
    .stall_cycles     (stall_cycles),
    .if_starve_cycles (if_starve_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; ram_rdata = '0; ram_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_req", ram_req, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_acks", {if_ack, d_ack}, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_stall", pipe_stall, 0);
    rst_n = 1'b1;
    tick();

    // IF-only fetch, memory ready in the first BUSY cycle
    if_req = 1'b1; if_addr = 32'h0000_0004; #1;
    check("if_stall_c0", pipe_stall, 1);
    tick();
    check("if_ram_req", ram_req, 1);
    check("if_ram_addr", ram_addr, 32'h4);
    check("if_ram_we", ram_we, 0);
    check("if_ack_c1", if_ack, 0);
    check("if_stall_c1", pipe_stall, 1);
    ram_ready = 1'b1; ram_rdata = 32'h8C22_0000;
    tick();
    check("if_ack_c2", if_ack, 1);
    check("if_rdata", if_rdata, 32'h8C22_0000);
    check("if_ram_req_drop", ram_req, 0);
    check("if_stall_c2", pipe_stall, 0);
    if_req = 1'b0; ram_ready = 1'b0; ram_rdata = '0;
    tick();
    check("if_ack_c3", if_ack, 0);
    tick();

    // MEM load and IF in the same cycle: MEM first, IF three cycles later
`ifdef ARB_PERF_COUNTERS_EN
    stall_base = stall_cycles; starve_base = if_starve_cycles;
`endif
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; if_req = 1'b1; if_addr = 32'h4;
    tick();
    check("cf_ram_addr_d", ram_addr, 32'h100);
    check("cf_ram_we_d", ram_we, 0);
    ram_ready = 1'b1; ram_rdata = 32'h1111_2222;
    tick();
    check("cf_d_ack", {d_ack, if_ack}, 2'b10);
    check("cf_d_rdata", d_rdata, 32'h1111_2222);
    check("cf_stall_if_wait", pipe_stall, 1);
    d_req = 1'b0; ram_ready = 1'b0; ram_rdata = '0;
    tick();
    check("cf_idle_gap", ram_req, 0);
    tick();
    check("cf_ram_req_i", ram_req, 1);
    check("cf_ram_addr_i", ram_addr, 32'h4);
    ram_ready = 1'b1; ram_rdata = 32'h8C22_0000;
    tick();
    check("cf_if_ack", {d_ack, if_ack}, 2'b01);
    check("cf_if_rdata", if_rdata, 32'h8C22_0000);
`ifdef ARB_PERF_COUNTERS_EN
    check("perf_stall_cycles", stall_cycles - stall_base, 5);
    check("perf_if_starve", if_starve_cycles - starve_base, 1);
`endif
    if_req = 1'b0; ram_ready = 1'b0; ram_rdata = '0;
    repeat (2) tick();

    // Store with memory ready in the third BUSY cycle
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("st_ram_held", {ram_req, ram_we, ram_addr, ram_wdata},
            {1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF});
      check("st_no_ack", d_ack, 0);
      if (i == 2) ram_ready = 1'b1;
      tick();
    end
    check("st_d_ack", d_ack, 1);
    check("st_ram_req_drop", ram_req, 0);
    d_req = 1'b0; d_we = 1'b0; ram_ready = 1'b0;
    tick();
    check("st_d_ack_pulse", d_ack, 0);
    tick();

    // Timeout: memory never responds
    if_req = 1'b1; if_addr = 32'h40;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
    end
    check("to_ram_req_last_busy", ram_req, 1);
    check("to_err_before", timeout_err, 0);
    tick();
    check("to_ram_req_drop", ram_req, 0);
    check("to_if_ack", if_ack, 1);
    check("to_if_rdata_zero", if_rdata, 0);
    check("to_err_set", timeout_err, 1);
    if_req = 1'b0;
    repeat (3) tick();
    check("to_err_sticky", timeout_err, 1);

    // Reset in the middle of a MEM transaction
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    tick();
    check("rm_busy", ram_req, 1);
    rst_n = 1'b0; #1;
    check("rm_ram_req_async", ram_req, 0);
    check("rm_acks", {d_ack, if_ack}, 0);
    check("rm_err_cleared", timeout_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rm_reissue", {ram_req, ram_addr}, {1'b1, 32'h200});
    ram_ready = 1'b1; ram_rdata = 32'hCAFE_F00D;
    tick();
    check("rm_d_ack", d_ack, 1);
    check("rm_d_rdata", d_rdata, 32'hCAFE_F00D);
    d_req = 1'b0; ram_ready = 1'b0; ram_rdata = '0;
    repeat (2) tick();

    // Stray ram_ready while idle is ignored
    ram_ready = 1'b1; ram_rdata = 32'h5555_AAAA;
    repeat (2) tick();
    check("stray_ready_acks", {d_ack, if_ack, ram_req}, 0);
    check("stray_ready_rdata", d_rdata, 32'hCAFE_F00D);
    ram_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
